// File: rtl/weight_loader_pkg.sv
// Shared types and constants for the weight loader: FSM states and the
// header word layout of the incoming weight segment stream.
package weight_loader_pkg;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    DATA = 2'd1,
    DROP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned HDR_CNT_MSB  = 31;
  localparam int unsigned HDR_CNT_LSB  = 16;
  localparam int unsigned HDR_ADDR_MSB = 15;
  localparam int unsigned HDR_ADDR_LSB = 0;
  localparam int unsigned WEIGHT_BUS_W = 32;

endpackage

// File: rtl/weight_loader.sv
// Converts a stream of (header, payload...) weight segments into registered
// single-word writes on the shared weight bus of the model.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int unsigned MAX_ADDR  = 137,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_start,
  input  logic [31:0]             s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [WEIGHT_BUS_W-1:0] weight_wr_data,
  output logic [WEIGHT_BUS_W-1:0] weight_wr_addr,
  output logic                    weight_wr_en,
  output logic                    load_done,
  output logic                    load_err,
  output logic [31:0]             word_cnt
);

  state_t                   state, state_next;
  logic [CNT_WIDTH-1:0]     remaining;
  logic [WEIGHT_BUS_W-1:0]  addr;
  logic                     accept;
  logic                     last_word;
  logic                     hdr_oob;
  logic [HDR_CNT_MSB-HDR_CNT_LSB:0]   hdr_cnt;
  logic [HDR_ADDR_MSB-HDR_ADDR_LSB:0] hdr_addr;
  logic [32:0]              hdr_end;

  assign hdr_cnt  = s_data[HDR_CNT_MSB:HDR_CNT_LSB];
  assign hdr_addr = s_data[HDR_ADDR_MSB:HDR_ADDR_LSB];
  // Last address of the segment in 33 bits so B+N-1 never wraps.
  assign hdr_end  = 33'(hdr_addr) + 33'(hdr_cnt) - 33'd1;
  assign hdr_oob  = hdr_end > 33'(MAX_ADDR);

  // rst_n gates ready so no word is taken while reset is held.
  assign s_ready   = rst_n && (state != DONE) && !load_start;
  assign accept    = s_valid && s_ready;
  assign last_word = (remaining == CNT_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HDR;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (load_start) begin
      state_next = HDR;
    end else if (accept) begin
      case (state)
        HDR: begin
          if (hdr_cnt == '0)  state_next = DONE;
          else if (hdr_oob)   state_next = DROP;
          else                state_next = DATA;
        end
        DATA, DROP: if (last_word) state_next = HDR;
        default:    state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining      <= '0;
      addr           <= '0;
      weight_wr_en   <= 1'b0;
      weight_wr_addr <= '0;
      weight_wr_data <= '0;
      load_done      <= 1'b0;
      load_err       <= 1'b0;
      word_cnt       <= '0;
    end else begin
      weight_wr_en <= 1'b0;
      if (load_start) begin
        load_done <= 1'b0;
        load_err  <= 1'b0;
        word_cnt  <= '0;
      end else if (accept) begin
        case (state)
          HDR: begin
            if (hdr_cnt == '0) begin
              load_done <= 1'b1;
            end else begin
              remaining <= CNT_WIDTH'(hdr_cnt);
              if (hdr_oob) load_err <= 1'b1;
              else         addr     <= WEIGHT_BUS_W'(hdr_addr);
            end
          end
          DATA: begin
            weight_wr_en   <= 1'b1;
            weight_wr_addr <= addr;
            weight_wr_data <= s_data;
            addr           <= addr + 1'b1;
            remaining      <= remaining - 1'b1;
            if (word_cnt != '1) word_cnt <= word_cnt + 1'b1;
          end
          DROP:    remaining <= remaining - 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: inputs driven 1ns after the rising edge,
// outputs checked in the same window.
module tb_weight_loader;

  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] weight_wr_data;
  logic [31:0] weight_wr_addr;
  logic        weight_wr_en;
  logic        load_done;
  logic        load_err;
  logic [31:0] word_cnt;

  int checks = 0;
  int errors = 0;

  weight_loader #(.MAX_ADDR(137), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .weight_wr_data(weight_wr_data), .weight_wr_addr(weight_wr_addr),
    .weight_wr_en(weight_wr_en), .load_done(load_done),
    .load_err(load_err), .word_cnt(word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    s_valid = 1'b0;
    load_start = 1'b1;
    cycle();
    load_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_start = 1'b0; s_valid = 1'b1; s_data = 32'h0002_0024;
    cycle(); cycle();
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b exp 0", s_ready); end
    checks++; if (weight_wr_en !== 1'b0 || weight_wr_addr !== 32'd0 || weight_wr_data !== 32'd0) begin
      errors++; $display("FAIL rst_wr got en=%0b addr=%0d data=%h exp 0/0/0", weight_wr_en, weight_wr_addr, weight_wr_data); end
    checks++; if (load_done !== 1'b0 || load_err !== 1'b0 || word_cnt !== 32'd0) begin
      errors++; $display("FAIL rst_status got done=%0b err=%0b cnt=%0d exp 0/0/0", load_done, load_err, word_cnt); end
    s_valid = 1'b0;
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_basic();
    s_valid = 1'b1; s_data = {16'd2, 16'd36};
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %0b exp 1", s_ready); end
    cycle();
    checks++; if (weight_wr_en !== 1'b0) begin errors++; $display("FAIL basic_hdr_wr got %0b exp 0", weight_wr_en); end
    s_data = 32'h0000_000A;
    cycle();
    checks++; if (weight_wr_en !== 1'b1 || weight_wr_addr !== 32'd36 || weight_wr_data !== 32'hA) begin
      errors++; $display("FAIL basic_w0 got en=%0b addr=%0d data=%h exp 1/36/a", weight_wr_en, weight_wr_addr, weight_wr_data); end
    s_data = 32'h0000_000B;
    cycle();
    checks++; if (weight_wr_en !== 1'b1 || weight_wr_addr !== 32'd37 || weight_wr_data !== 32'hB) begin
      errors++; $display("FAIL basic_w1 got en=%0b addr=%0d data=%h exp 1/37/b", weight_wr_en, weight_wr_addr, weight_wr_data); end
    s_data = 32'h0000_0000;
    cycle();
    s_valid = 1'b0;
    checks++; if (weight_wr_en !== 1'b0) begin errors++; $display("FAIL basic_term_wr got %0b exp 0", weight_wr_en); end
    checks++; if (load_done !== 1'b1 || word_cnt !== 32'd2) begin
      errors++; $display("FAIL basic_done got done=%0b cnt=%0d exp 1/2", load_done, word_cnt); end
    s_valid = 1'b1; s_data = {16'd1, 16'd10};
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL basic_done_ready got %0b exp 0", s_ready); end
    cycle();
    s_valid = 1'b0;
    checks++; if (weight_wr_en !== 1'b0 || load_done !== 1'b1) begin
      errors++; $display("FAIL basic_done_hold got en=%0b done=%0b exp 0/1", weight_wr_en, load_done); end
  endtask

  task automatic test_drop();
    start_pulse();
    checks++; if (load_done !== 1'b0 || word_cnt !== 32'd0) begin
      errors++; $display("FAIL drop_clear got done=%0b cnt=%0d exp 0/0", load_done, word_cnt); end
    s_valid = 1'b1; s_data = {16'd4, 16'd136};
    cycle();
    checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL drop_err got %0b exp 1", load_err); end
    for (int i = 0; i < 4; i++) begin
      s_data = 32'h1000 + 32'(i);
      cycle();
      checks++; if (weight_wr_en !== 1'b0) begin errors++; $display("FAIL drop_nowr%0d got %0b exp 0", i, weight_wr_en); end
    end
    s_data = {16'd1, 16'd0};
    cycle();
    s_data = 32'h55;
    cycle();
    s_valid = 1'b0;
    checks++; if (weight_wr_en !== 1'b1 || weight_wr_addr !== 32'd0 || weight_wr_data !== 32'h55) begin
      errors++; $display("FAIL drop_after got en=%0b addr=%0d data=%h exp 1/0/55", weight_wr_en, weight_wr_addr, weight_wr_data); end
    checks++; if (word_cnt !== 32'd1 || load_err !== 1'b1) begin
      errors++; $display("FAIL drop_status got cnt=%0d err=%0b exp 1/1", word_cnt, load_err); end
  endtask

  task automatic test_boundary();
    start_pulse();
    s_valid = 1'b1; s_data = {16'd2, 16'd136};
    cycle();
    s_data = 32'hC0DE_0001;
    cycle();
    checks++; if (weight_wr_en !== 1'b1 || weight_wr_addr !== 32'd136) begin
      errors++; $display("FAIL bnd_w0 got en=%0b addr=%0d exp 1/136", weight_wr_en, weight_wr_addr); end
    s_data = 32'hC0DE_0002;
    cycle();
    checks++; if (weight_wr_en !== 1'b1 || weight_wr_addr !== 32'd137 || weight_wr_data !== 32'hC0DE_0002) begin
      errors++; $display("FAIL bnd_w1 got en=%0b addr=%0d data=%h exp 1/137/c0de0002", weight_wr_en, weight_wr_addr, weight_wr_data); end
    checks++; if (load_err !== 1'b0 || word_cnt !== 32'd2) begin
      errors++; $display("FAIL bnd_status got err=%0b cnt=%0d exp 0/2", load_err, word_cnt); end
    s_data = {16'd1, 16'd138};
    cycle();
    s_data = 32'hDEAD;
    cycle();
    s_valid = 1'b0;
    checks++; if (load_err !== 1'b1 || weight_wr_en !== 1'b0 || word_cnt !== 32'd2) begin
      errors++; $display("FAIL bnd_over got err=%0b en=%0b cnt=%0d exp 1/0/2", load_err, weight_wr_en, word_cnt); end
  endtask

  task automatic test_bubble();
    start_pulse();
    s_valid = 1'b1; s_data = {16'd2, 16'd40};
    cycle();
    s_data = 32'h11;
    cycle();
    checks++; if (weight_wr_en !== 1'b1 || weight_wr_addr !== 32'd40) begin
      errors++; $display("FAIL bub_w0 got en=%0b addr=%0d exp 1/40", weight_wr_en, weight_wr_addr); end
    s_valid = 1'b0; s_data = 32'h99;
    cycle();
    checks++; if (weight_wr_en !== 1'b0 || weight_wr_addr !== 32'd40 || weight_wr_data !== 32'h11) begin
      errors++; $display("FAIL bub_gap got en=%0b addr=%0d data=%h exp 0/40/11", weight_wr_en, weight_wr_addr, weight_wr_data); end
    s_valid = 1'b1; s_data = 32'h22;
    cycle();
    s_valid = 1'b0;
    checks++; if (weight_wr_en !== 1'b1 || weight_wr_addr !== 32'd41 || weight_wr_data !== 32'h22) begin
      errors++; $display("FAIL bub_w1 got en=%0b addr=%0d data=%h exp 1/41/22", weight_wr_en, weight_wr_addr, weight_wr_data); end
  endtask

  task automatic test_start_mid();
    start_pulse();
    s_valid = 1'b1; s_data = {16'd3, 16'd50};
    cycle();
    s_data = 32'h1;
    cycle();
    checks++; if (weight_wr_en !== 1'b1 || weight_wr_addr !== 32'd50) begin
      errors++; $display("FAIL mid_w0 got en=%0b addr=%0d exp 1/50", weight_wr_en, weight_wr_addr); end
    load_start = 1'b1; s_data = 32'h2;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got %0b exp 0", s_ready); end
    cycle();
    load_start = 1'b0;
    checks++; if (word_cnt !== 32'd0 || weight_wr_en !== 1'b0) begin
      errors++; $display("FAIL mid_clear got cnt=%0d en=%0b exp 0/0", word_cnt, weight_wr_en); end
    s_data = {16'd1, 16'd60};
    cycle();
    checks++; if (weight_wr_en !== 1'b0) begin errors++; $display("FAIL mid_hdr got %0b exp 0", weight_wr_en); end
    s_data = 32'h77;
    cycle();
    s_valid = 1'b0;
    checks++; if (weight_wr_en !== 1'b1 || weight_wr_addr !== 32'd60 || weight_wr_data !== 32'h77) begin
      errors++; $display("FAIL mid_w got en=%0b addr=%0d data=%h exp 1/60/77", weight_wr_en, weight_wr_addr, weight_wr_data); end
  endtask

  task automatic test_reset_mid();
    start_pulse();
    s_valid = 1'b1; s_data = {16'd3, 16'd70};
    cycle();
    s_data = 32'h5;
    cycle();
    checks++; if (weight_wr_en !== 1'b1 || weight_wr_addr !== 32'd70) begin
      errors++; $display("FAIL rmid_w0 got en=%0b addr=%0d exp 1/70", weight_wr_en, weight_wr_addr); end
    rst_n = 1'b0;
    #1;
    checks++; if (weight_wr_en !== 1'b0 || weight_wr_addr !== 32'd0 || weight_wr_data !== 32'd0 || word_cnt !== 32'd0 || s_ready !== 1'b0) begin
      errors++; $display("FAIL rmid_async got en=%0b addr=%0d data=%h cnt=%0d rdy=%0b exp 0/0/0/0/0",
                         weight_wr_en, weight_wr_addr, weight_wr_data, word_cnt, s_ready); end
    s_valid = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    s_valid = 1'b1; s_data = {16'd1, 16'd80};
    cycle();
    s_data = 32'h99;
    cycle();
    s_valid = 1'b0;
    checks++; if (weight_wr_en !== 1'b1 || weight_wr_addr !== 32'd80 || weight_wr_data !== 32'h99) begin
      errors++; $display("FAIL rmid_after got en=%0b addr=%0d data=%h exp 1/80/99", weight_wr_en, weight_wr_addr, weight_wr_data); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drop();
    test_boundary();
    test_bubble();
    test_start_mid();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Sits directly upstream of the model top. Drives its weight_wr_data / weight_wr_addr / weight_wr_en bus, which is shared by every conv layer.
- Consumes a 32-bit valid/ready stream of weight segments and converts them into registered single-word writes at consecutive addresses.
- Each segment is a header word followed by payload words. A header with count 0 terminates the table and raises load_done.
- Out-of-range segments are consumed but not written, and are flagged.

Parameters:
- MAX_ADDR, 137: highest legal weight address (inclusive); the top-level sets it to the last LAYER_SCALE_BASE_ADDR.
- CNT_WIDTH, 16: width of the header count field and of the per-segment counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- load_start  in  1  one-cycle pulse; clears status and re-arms the loader
- s_data  in  32  stream word
- s_valid  in  1  stream word valid
- s_ready  out  1  loader accepts the word this cycle
- weight_wr_data  out  32  write data to the model
- weight_wr_addr  out  32  write address to the model
- weight_wr_en  out  1  write strobe, one cycle per word
- load_done  out  1  sticky; the table terminator has been received
- load_err  out  1  sticky; at least one segment was out of range
- word_cnt  out  32  total payload words actually written since the last start or reset

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - FSM goes to HDR.
  - s_ready=0 during reset.
  - weight_wr_en=0, weight_wr_addr=0, weight_wr_data=0.
  - load_done=0, load_err=0, word_cnt=0.
  - Internal base/count registers are 0.
- Handshake: a word transfers when s_valid && s_ready on a rising edge of clk.
  - s_ready = (state==HDR || state==DATA || state==DROP) && !load_start. This is combinational from state.
- Header format:
  - s_data[31:16] = count N.
  - s_data[15:0] = base address B, zero-extended to 32 bits.
- FSM states:
  - HDR, on an accepted word:
    - N==0 -> DONE; load_done<=1.
    - Else if B+N-1 > MAX_ADDR (computed in 17+ bits, no wrap) -> DROP; load_err<=1; remaining<=N.
    - Else -> DATA; addr<=B; remaining<=N.
  - DATA, on an accepted word:
    - Next cycle: weight_wr_en=1, weight_wr_addr=addr, weight_wr_data=s_data. Latency is exactly 1 cycle from acceptance.
    - addr<=addr+1, remaining<=remaining-1, word_cnt<=word_cnt+1.
    - If remaining==1 -> HDR.
  - DROP: accepts words and decrements remaining with no write and no word_cnt change. If remaining==1 -> HDR.
  - DONE: s_ready=0. Only load_start or rst_n leaves this state.
- weight_wr_en is high only in the cycle following a DATA acceptance; otherwise it is 0.
  - Address and data hold their last value when the strobe is low.
  - Back-to-back accepts give back-to-back strobes. Gaps in s_valid produce gaps in the strobe. Bubbles are legal.
- load_start, from any state:
  - Next state is HDR; load_done, load_err and word_cnt clear to 0.
  - s_ready is 0 that cycle, so no word is consumed.
  - A write strobe already registered from the previous cycle still completes.
- Reset mid-segment discards the segment. After reset the first accepted word is treated as a header.
- A header with N=65535 and B=0 is legal only if MAX_ADDR ≥ 65534; otherwise it goes to DROP.
- A segment ending exactly at MAX_ADDR is legal.
- word_cnt saturates at 2^32-1.

Decomposition:
- Shared package holds:
  - State encoding enum: HDR, DATA, DROP, DONE.
  - Header field constants: HDR_CNT_MSB=31, HDR_CNT_LSB=16, HDR_ADDR_MSB=15, HDR_ADDR_LSB=0.
  - WEIGHT_BUS_W=32.
- Single module. No sub-module is natural; the write register stage is inline.

Test Plan:
- Reset, then header N=2/B=36, then words 0xA, 0xB, then header 0x00000000 -> writes (36,0xA) and (37,0xB) on consecutive cycles, each one cycle after acceptance; load_done=1; word_cnt=2; s_ready=0 afterwards.
- Header N=4/B=136 with MAX_ADDR=137 -> load_err=1; 4 payload words consumed with no weight_wr_en; next header N=1/B=0 with word 0x55 -> write (0,0x55); word_cnt=1.
- Header N=2/B=136 (ends exactly at 137) -> two writes at 136 and 137, load_err=0.
- s_valid toggling 1,0,1 during DATA -> strobes separated by one idle cycle; addresses still 40, 41.
- load_start asserted while in DATA with s_valid=1 -> s_ready=0 that cycle; status and word_cnt clear; next word accepted is parsed as a header.
- rst_n pulsed low mid-segment (after 1 of 3 words) -> all outputs 0 immediately (asynchronous); after release, the next word is treated as a header.
